round_clip_27: RTL and testbench



---
 rtl/round_clip_27_if.sv | 24 ++
 rtl/round_clip_27.sv | 128 ++++++++++++
 tb/tb_round_clip_27.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/round_clip_27_if.sv
// FIFO-bank read and single-FIFO write interfaces used by round_clip_27.
// The actor modports are the consumer/producer side; fifo modports are the FIFO side.
interface read_interface #(
    parameter int FLUX  = 2,
    parameter int WIDTH = 28
);
    logic [FLUX-1:0]  empty;
    logic [FLUX-1:0]  read;
    logic [WIDTH-1:0] dout;

    modport actor (input empty, input dout, output read);
    modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int WIDTH = 17
);
    logic             full;
    logic             write;
    logic [WIDTH-1:0] din;

    modport actor (input full, output write, output din);
    modport fifo  (output full, input write, input din);
endinterface

// File: rtl/round_clip_27.sv
// Round (half-up) and clip of tagged 27-bit sums, 2-stage pipeline, round-robin over FLUX FIFOs.
// Optional ROUND_CLIP_27_CLIP_COUNT_EN adds a saturating count of clipped written samples.
module round_clip_27 #(
    parameter int FLUX      = 2,
    parameter int SHIFT     = 7,
    parameter int OUT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    read_interface.actor  read_port,
    write_interface.actor write_port
`ifdef ROUND_CLIP_27_CLIP_COUNT_EN
    ,
    output logic [15:0]   clip_count
`endif
);
    localparam int TAG_WIDTH  = $clog2(FLUX);
    localparam int DATA_WIDTH = 27;
    localparam int SUM_WIDTH  = DATA_WIDTH + 1;
    localparam int unsigned FLUX_N = FLUX;

    localparam logic [TAG_WIDTH-1:0] LAST_FLUX = TAG_WIDTH'(FLUX - 1);
    localparam logic signed [SUM_WIDTH-1:0] ROUND_BIAS = SUM_WIDTH'(64'd1 << (SHIFT - 1));
    localparam logic signed [SUM_WIDTH-1:0] OUT_MAX    = SUM_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SUM_WIDTH-1:0] OUT_MIN    = SUM_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    logic                        v1, v2;
    logic [TAG_WIDTH-1:0]        tag1, tag2, rr_ptr;
    logic signed [SUM_WIDTH-1:0] r1;
    logic [OUT_WIDTH-1:0]        q2;

    logic                        en1, en2, accept, wr;
    logic                        found_hi, found_lo;
    logic [TAG_WIDTH-1:0]        sel_hi, sel_lo, sel, ptr_next;
    logic [FLUX-1:0]             read_vec;
    logic signed [SUM_WIDTH-1:0] sum_next, shifted;
    logic                        too_high, too_low;
    logic [OUT_WIDTH-1:0]        q_next;

    assign en2 = ~v2 | ~write_port.full;
    assign en1 = ~v1 | en2;

    // Rotating priority split into two passes: first non-empty at or above rr_ptr wins,
    // otherwise the lowest non-empty flux (the wrapped part of the scan).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int unsigned f = 0; f < FLUX_N; f++) begin
            if (!read_port.empty[f]) begin
                if (!found_hi && (TAG_WIDTH'(f) >= rr_ptr)) begin
                    sel_hi   = TAG_WIDTH'(f);
                    found_hi = 1'b1;
                end
                if (!found_lo) begin
                    sel_lo   = TAG_WIDTH'(f);
                    found_lo = 1'b1;
                end
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    assign accept   = en1 & found_lo & ~rst;
    assign ptr_next = (sel == LAST_FLUX) ? '0 : sel + 1'b1;

    always_comb begin
        read_vec = '0;
        if (accept) read_vec[sel] = 1'b1;
    end

    assign read_port.read = read_vec;

    assign sum_next = $signed({read_port.dout[DATA_WIDTH-1], read_port.dout[DATA_WIDTH-1:0]}) + ROUND_BIAS;

    always_comb begin
        shifted  = r1 >>> SHIFT;
        too_high = shifted > OUT_MAX;
        too_low  = shifted < OUT_MIN;
        q_next   = shifted[OUT_WIDTH-1:0];
        if (too_high) q_next = OUT_MAX[OUT_WIDTH-1:0];
        if (too_low)  q_next = OUT_MIN[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            tag1   <= '0;
            r1     <= '0;
            v2     <= 1'b0;
            tag2   <= '0;
            q2     <= '0;
            rr_ptr <= '0;
        end else begin
            if (en1) begin
                v1   <= accept;
                tag1 <= sel;
                r1   <= sum_next;
            end
            if (en2) begin
                v2   <= v1;
                tag2 <= tag1;
                q2   <= q_next;
            end
            if (accept) rr_ptr <= ptr_next;
        end
    end

    assign wr               = v2 & ~write_port.full & ~rst;
    assign write_port.write = wr;
    assign write_port.din   = {tag2, q2};

`ifdef ROUND_CLIP_27_CLIP_COUNT_EN
    logic clip2;

    always_ff @(posedge clk) begin
        if (rst) begin
            clip2      <= 1'b0;
            clip_count <= '0;
        end else begin
            if (en2) clip2 <= too_high | too_low;
            if (wr && clip2 && (clip_count != 16'hFFFF)) clip_count <= clip_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_round_clip_27.sv
// Directed bench for round_clip_27: FWFT FIFO bank model, read/write monitors, vector table.
module tb_round_clip_27;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    read_interface  #(.FLUX(2), .WIDTH(28)) rd_if ();
    write_interface #(.WIDTH(17))           wr_if ();
`ifdef ROUND_CLIP_27_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    round_clip_27 #(.FLUX(2), .SHIFT(7), .OUT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_port  (rd_if),
        .write_port (wr_if)
`ifdef ROUND_CLIP_27_CLIP_COUNT_EN
        ,
        .clip_count (clip_count)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // FIFO bank model: tail/mem owned by the stimulus, head by the pop process
    logic [26:0] mem [2][256];
    int head [2] = '{0, 0};
    int tail [2] = '{0, 0};

    always_comb begin
        for (int f = 0; f < 2; f++) rd_if.empty[f] = (head[f] == tail[f]);
        // tag field set opposite to the real flux so an output tag copied from it shows up
        rd_if.dout = {1'b1, mem[0][head[0] % 256]};
        if (rd_if.read[1]) rd_if.dout = {1'b0, mem[1][head[1] % 256]};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int f = 0; f < 2; f++) if (rd_if.read[f]) head[f] <= head[f] + 1;
    end

    int rd_cyc[$], rd_flux[$], wr_cyc[$], wr_tag[$], wr_data[$];
    int multi_read = 0;
    int rst_activity = 0;

    always @(negedge clk) begin
        for (int f = 0; f < 2; f++) begin
            if (rd_if.read[f]) begin
                rd_cyc.push_back(cyc);
                rd_flux.push_back(f);
            end
        end
        if (wr_if.write) begin
            wr_cyc.push_back(cyc);
            wr_tag.push_back(int'(wr_if.din[16]));
            wr_data.push_back(int'($signed(wr_if.din[15:0])));
        end
        if (rd_if.read == 2'b11) multi_read++;
        if (rst && (wr_if.write || (rd_if.read != 2'b00))) rst_activity++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int f, input int v);
        mem[f][tail[f] % 256] = 27'(v);
        tail[f] = tail[f] + 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (wr_data.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (wr_data.size() < n) check({name, "_timeout"}, wr_data.size(), n);
    endtask

    typedef struct {
        int din;
        int exp_q;
        int exp_clip;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int br, bw, nclip, k;

        vecs[0]  = '{448,       4,      0};
        vecs[1]  = '{-192,      -1,     0};
        vecs[2]  = '{67108863,  32767,  1};
        vecs[3]  = '{-67108864, -32768, 1};
        vecs[4]  = '{63,        0,      0};
        vecs[5]  = '{64,        1,      0};
        vecs[6]  = '{-64,       0,      0};
        vecs[7]  = '{-65,       -1,     0};
        vecs[8]  = '{4194239,   32767,  0};
        vecs[9]  = '{4194240,   32767,  1};
        vecs[10] = '{-4194304,  -32768, 0};
        vecs[11] = '{-4194369,  -32768, 1};

        rst = 1'b1;
        wr_if.full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_write", int'(wr_if.write), 0);
        check("reset_read", int'(rd_if.read), 0);
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef ROUND_CLIP_27_CLIP_COUNT_EN
        @(negedge clk);
        check("reset_clip_count", int'(clip_count), 0);
`endif

        // vector table on flux 0
        do_reset();
        br = rd_cyc.size();
        bw = wr_data.size();
        @(posedge clk);
        #1;
        nclip = 0;
        for (int i = 0; i < 12; i++) begin
            push(0, vecs[i].din);
            nclip += vecs[i].exp_clip;
        end
        wait_writes(bw + 12, 40, "table");
        for (int i = 0; i < 12; i++) begin
            if (bw + i < wr_data.size() && br + i < rd_cyc.size()) begin
                check($sformatf("table_q[%0d]", i), wr_data[bw + i], vecs[i].exp_q);
                check($sformatf("table_tag[%0d]", i), wr_tag[bw + i], 0);
                check($sformatf("table_lat[%0d]", i), wr_cyc[bw + i] - rd_cyc[br + i], 2);
                check($sformatf("table_rate[%0d]", i), wr_cyc[bw + i] - wr_cyc[bw], i);
            end
        end
`ifdef ROUND_CLIP_27_CLIP_COUNT_EN
        @(posedge clk);
        @(negedge clk);
        check("clip_count", int'(clip_count), nclip);
`endif

        // round-robin from reset
        do_reset();
        br = rd_cyc.size();
        bw = wr_data.size();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            push(0, 128 * i);
            push(1, -128 * i);
        end
        wait_writes(bw + 8, 30, "rr");
        for (int i = 0; i < 8; i++) begin
            if (bw + i < wr_data.size()) begin
                check($sformatf("rr_read_flux[%0d]", i), rd_flux[br + i], i % 2);
                check($sformatf("rr_tag[%0d]", i), wr_tag[bw + i], i % 2);
                check($sformatf("rr_q[%0d]", i), wr_data[bw + i], (i % 2 == 1) ? -(i / 2 + 1) : (i / 2 + 1));
                check($sformatf("rr_rate[%0d]", i), wr_cyc[bw + i] - wr_cyc[bw], i);
            end
        end

        // backpressure: full held while three samples wait on flux 1
        do_reset();
        br = rd_cyc.size();
        bw = wr_data.size();
        @(posedge clk);
        #1 wr_if.full = 1'b1;
        push(1, 256);
        push(1, 384);
        push(1, 512);
        k = 0;
        while (rd_cyc.size() == br && k < 10) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("bp_reads_while_full", rd_cyc.size() - br, 2);
        check("bp_writes_while_full", wr_data.size() - bw, 0);
        wr_if.full = 1'b0;
        wait_writes(bw + 3, 20, "bp");
        for (int i = 0; i < 3; i++) begin
            if (bw + i < wr_data.size()) begin
                check($sformatf("bp_q[%0d]", i), wr_data[bw + i], i + 2);
                check($sformatf("bp_tag[%0d]", i), wr_tag[bw + i], 1);
            end
        end
        if (br + 2 < rd_cyc.size() && bw < wr_cyc.size())
            check("bp_read_write_same_cycle", rd_cyc[br + 2], wr_cyc[bw]);
        else
            check("bp_third_read", rd_cyc.size() - br, 3);

        // reset with both stages occupied
        do_reset();
        br = rd_cyc.size();
        bw = wr_data.size();
        @(posedge clk);
        #1 wr_if.full = 1'b1;
        push(0, 1280);
        push(0, 1408);
        repeat (2) @(posedge clk);
        #1;
        push(0, 1536);
        push(1, 1664);
        @(posedge clk);
        #1;
        check("mid_reads_before_rst", rd_cyc.size() - br, 2);
        check("mid_writes_before_rst", wr_data.size() - bw, 0);
        rst = 1'b1;
        wr_if.full = 1'b0;
        @(negedge clk);
        check("mid_read_in_rst", int'(rd_if.read), 0);
        check("mid_write_in_rst", int'(wr_if.write), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_write_after_rst", int'(wr_if.write), 0);
        check("mid_first_read_flux0", int'(rd_if.read), 1);
        wait_writes(bw + 2, 20, "mid");
        repeat (5) @(posedge clk);
        #1;
        check("mid_write_count", wr_data.size() - bw, 2);
        if (bw + 1 < wr_data.size()) begin
            check("mid_q0", wr_data[bw], 12);
            check("mid_tag0", wr_tag[bw], 0);
            check("mid_q1", wr_data[bw + 1], 13);
            check("mid_tag1", wr_tag[bw + 1], 1);
        end

        check("one_hot_read", multi_read, 0);
        check("activity_during_rst", rst_activity, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
